// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared state encodings and default constants for timebase_ctrl
package timebase_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } tb_state_t;

    localparam int DEF_TICK_DIV   = 25000000;
    localparam int DEF_DEB_CYCLES = 500000;

    // Width of a counter that must hold values 0..max_val.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, debouncer and press-pulse generator for one active-low key
module key_debounce
    import timebase_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int CW = count_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Bring the raw pushbutton into the clk domain; released level is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // One-cycle press pulse the cycle after the accepted level falls; releases are silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level_d & ~level;
        end
    end

endmodule

// File: rtl/timebase_ctrl.sv
// rtl/timebase_ctrl.sv - run/pause timebase with prescaler, single-step and legacy slow clock
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run_key,
    input  logic step_key,
    output logic tick,
    output logic slow_clk,
    output logic running
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_PREV = PW'(TICK_DIV - 2);

    tb_state_t     state;
    logic [PW-1:0] presc;
    logic          run_press;
    logic          step_press;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_run_key (
        .clk  (clk),
        .reset(reset),
        .key  (run_key),
        .press(run_press)
    );

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_key (
        .clk  (clk),
        .reset(reset),
        .key  (step_key),
        .press(step_press)
    );

    // Run/pause FSM with prescaler; tick is registered from the next prescaler value so it
    // lines up with the cycle where the prescaler sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            running  <= 1'b1;
            presc    <= '0;
            tick     <= 1'b0;
            slow_clk <= 1'b0;
        end else begin
            slow_clk <= slow_clk ^ tick;
            case (state)
                ST_RUN: begin
                    if (run_press) begin
                        // The boundary tick (if any) is already on the output this cycle.
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                        presc   <= '0;
                        tick    <= 1'b0;
                    end else begin
                        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
                        tick  <= (presc == PRESC_PREV);
                    end
                end
                ST_PAUSE: begin
                    presc <= '0;
                    if (run_press) begin
                        // Run toggle wins over a coincident step; count restarts from 0.
                        state   <= ST_RUN;
                        running <= 1'b1;
                        tick    <= 1'b0;
                    end else begin
                        tick <= step_press;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                    presc   <= '0;
                    tick    <= 1'b0;
                end
            endcase
        end
    end

endmodule
